// File: rtl/lab7_input_pkg.sv
// Shared types and constants for the user-input conditioning stage.
package lab7_input_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} debounce_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int SYNC_STAGES             = 2;
endpackage

// File: rtl/key_debounce.sv
// One pushbutton: invert, synchronize, debounce with a press/release FSM,
// and emit a registered level plus a one-cycle press strobe.
module key_debounce
    import lab7_input_pkg::*;
#(
    parameter int N         = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH = $clog2(N)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic pulse
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(N - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   key_sync;
    debounce_state_t        state;
    logic [CNT_WIDTH-1:0]   cnt;

    assign key_sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
            state   <= IDLE;
            cnt     <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], ~key_n};
            pulse   <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_sync) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_sync) begin
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state <= PRESSED;
                        level <= 1'b1;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!key_sync) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to active during release keeps the key held.
                    if (key_sync) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/lab7_input_conditioner.sv
// Conditions raw pushbuttons and slide switches into clean, debounced PIO
// levels and press strobes; clear takes priority over accumulate strobes.
module lab7_input_conditioner
    import lab7_input_pkg::*;
#(
    parameter int SW_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                key_clear_n,
    input  logic                key_accum_n,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic                clear_export,
    output logic                accumulate_export,
    output logic [SW_WIDTH-1:0] switch_export,
    output logic                clear_pulse,
    output logic                accumulate_pulse
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic accum_pulse_raw;

    key_debounce #(.N(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_clear (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .key_n (key_clear_n),
        .level (clear_export),
        .pulse (clear_pulse)
    );

    key_debounce #(.N(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_accum (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .key_n (key_accum_n),
        .level (accumulate_export),
        .pulse (accum_pulse_raw)
    );

    // Software must never see an accumulate strobe while a clear is active.
    assign accumulate_pulse = accum_pulse_raw & ~clear_export & ~clear_pulse;

    logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_meta;
    logic [SW_WIDTH-1:0]                  sw_sync;
    logic [SW_WIDTH-1:0]                  sw_cand;
    logic [CNT_WIDTH-1:0]                 sw_cnt;

    assign sw_sync = sw_meta[SYNC_STAGES-1];

    // Whole-vector tracker: any bit change restarts the stability count.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sw_meta       <= '0;
            sw_cand       <= '0;
            sw_cnt        <= '0;
            switch_export <= '0;
        end else begin
            sw_meta <= {sw_meta[SYNC_STAGES-2:0], sw_raw};
            if (sw_sync != sw_cand) begin
                sw_cand <= sw_sync;
                sw_cnt  <= '0;
            end else if (sw_cnt == CNT_MAX) begin
                switch_export <= sw_cand;
            end else begin
                sw_cnt <= sw_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lab7_input_conditioner.sv
// Bench for lab7_input_conditioner with N=4: directed timing scenarios plus
// randomized traffic checked against a run-length behavioural model.
module tb_lab7_input_conditioner;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic       key_accum_n = 1'b1;
    logic [7:0] sw_raw = 8'h00;
    logic       clear_export, accumulate_export, clear_pulse, accumulate_pulse;
    logic [7:0] switch_export;

    int n_checks = 0;
    int n_fail   = 0;

    lab7_input_conditioner #(.SW_WIDTH(8), .DEBOUNCE_CYCLES(N)) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .key_clear_n       (key_clear_n),
        .key_accum_n       (key_accum_n),
        .sw_raw            (sw_raw),
        .clear_export      (clear_export),
        .accumulate_export (accumulate_export),
        .switch_export     (switch_export),
        .clear_pulse       (clear_pulse),
        .accumulate_pulse  (accumulate_pulse)
    );

    always #5 clk = ~clk;

    // Reference: a change is accepted once the synchronized value has
    // disagreed with (keys) or held steady at (switches) for N+1 samples.
    typedef struct {bit lvl; bit pls; int run;} km_t;

    function automatic km_t key_model(km_t c, bit s);
        km_t n;
        n = c;
        n.pls = 1'b0;
        if (s != c.lvl) begin
            n.run = c.run + 1;
            if (n.run == N + 1) begin
                n.lvl = s;
                n.pls = s;
                n.run = 0;
            end
        end else begin
            n.run = 0;
        end
        return n;
    endfunction

    bit [1:0]   h_clr, h_acc;
    bit [7:0]   h_sw [2];
    km_t        mc, ma;
    bit [7:0]   ms_prev, ms_exp;
    int         ms_run;
    bit         m_acc_pulse;

    assign m_acc_pulse = ma.pls & ~mc.lvl & ~mc.pls;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_clr   <= '0;
            h_acc   <= '0;
            h_sw[0] <= '0;
            h_sw[1] <= '0;
            mc      <= '{0, 0, 0};
            ma      <= '{0, 0, 0};
            ms_prev <= '0;
            ms_run  <= 1;
            ms_exp  <= '0;
        end else begin
            mc      <= key_model(mc, h_clr[1]);
            ma      <= key_model(ma, h_acc[1]);
            h_clr   <= {h_clr[0], ~key_clear_n};
            h_acc   <= {h_acc[0], ~key_accum_n};
            h_sw[0] <= sw_raw;
            h_sw[1] <= h_sw[0];
            if (h_sw[1] == ms_prev) begin
                ms_run <= (ms_run >= N + 1) ? ms_run : ms_run + 1;
                if (ms_run + 1 >= N + 1) ms_exp <= ms_prev;
            end else begin
                ms_prev <= h_sw[1];
                ms_run  <= 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        key_clear_n = 1'b1;
        key_accum_n = 1'b1;
        sw_raw = 8'h00;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        key_clear_n = 1'b0;
        key_accum_n = 1'b0;
        sw_raw = 8'hA5;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({clear_export, accumulate_export, clear_pulse, accumulate_pulse, switch_export} !== 12'h0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got %b%b%b%b sw=%h expected all zero",
                         i, clear_export, accumulate_export, clear_pulse, accumulate_pulse, switch_export);
            end
            tick();
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_checks++;
            if (clear_export !== (i >= 7) || accumulate_export !== (i >= 7)) begin
                n_fail++;
                $display("FAIL reset_release_level edge=%0d got clr=%b acc=%b expected %b",
                         i, clear_export, accumulate_export, i >= 7);
            end
            n_checks++;
            if (clear_pulse !== (i == 7) || accumulate_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release_pulse edge=%0d got clr=%b acc=%b expected clr=%b acc=0",
                         i, clear_pulse, accumulate_pulse, i == 7);
            end
            n_checks++;
            if (switch_export !== ((i >= 7) ? 8'hA5 : 8'h00)) begin
                n_fail++;
                $display("FAIL reset_release_sw edge=%0d got %h expected %h",
                         i, switch_export, (i >= 7) ? 8'hA5 : 8'h00);
            end
        end
        settle();
    endtask

    task automatic test_clean_press();
        key_accum_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (accumulate_export !== (i >= 7) || accumulate_pulse !== (i == 7)) begin
                n_fail++;
                $display("FAIL clean_press edge=%0d got lvl=%b pls=%b expected lvl=%b pls=%b",
                         i, accumulate_export, accumulate_pulse, i >= 7, i == 7);
            end
        end
        key_accum_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (accumulate_export !== (i < 7) || accumulate_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_release edge=%0d got lvl=%b pls=%b expected lvl=%b pls=0",
                         i, accumulate_export, accumulate_pulse, i < 7);
            end
        end
        settle();
    endtask

    task automatic test_bounce();
        int npulse;
        for (int c = 0; c < 30; c++) begin
            key_clear_n = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            n_checks++;
            if (clear_export !== 1'b0 || clear_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_reject cyc=%0d got lvl=%b pls=%b expected 0 0",
                         c, clear_export, clear_pulse);
            end
        end
        key_clear_n = 1'b0;
        npulse = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            npulse += int'(clear_pulse);
            n_checks++;
            if (clear_export !== (i >= 7) || clear_pulse !== (i == 7)) begin
                n_fail++;
                $display("FAIL bounce_hold edge=%0d got lvl=%b pls=%b expected lvl=%b pls=%b",
                         i, clear_export, clear_pulse, i >= 7, i == 7);
            end
        end
        n_checks++;
        if (npulse != 1) begin
            n_fail++;
            $display("FAIL bounce_pulse_count got %0d expected 1", npulse);
        end
        settle();
    endtask

    task automatic test_switch_glitch();
        sw_raw = 8'h0F;
        tick();
        tick();
        sw_raw = 8'h00;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (switch_export !== 8'h00) begin
                n_fail++;
                $display("FAIL sw_glitch cyc=%0d got %h expected 00", i, switch_export);
            end
        end
        sw_raw = 8'h0F;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_checks++;
            if (switch_export !== ((i >= 7) ? 8'h0F : 8'h00)) begin
                n_fail++;
                $display("FAIL sw_sustain edge=%0d got %h expected %h",
                         i, switch_export, (i >= 7) ? 8'h0F : 8'h00);
            end
        end
        settle();
    endtask

    task automatic test_simultaneous();
        key_clear_n = 1'b0;
        key_accum_n = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_checks++;
            if (clear_export !== (i >= 7) || accumulate_export !== (i >= 7)) begin
                n_fail++;
                $display("FAIL simul_level edge=%0d got clr=%b acc=%b expected %b",
                         i, clear_export, accumulate_export, i >= 7);
            end
            n_checks++;
            if (clear_pulse !== (i == 7) || accumulate_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL simul_pulse edge=%0d got clr=%b acc=%b expected clr=%b acc=0",
                         i, clear_pulse, accumulate_pulse, i == 7);
            end
        end
        settle();
    endtask

    task automatic test_mid_reset();
        key_accum_n = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({clear_export, accumulate_export, clear_pulse, accumulate_pulse, switch_export} !== 12'h0) begin
                n_fail++;
                $display("FAIL mid_reset_hold cyc=%0d got %b%b%b%b sw=%h expected all zero",
                         i, clear_export, accumulate_export, clear_pulse, accumulate_pulse, switch_export);
            end
            tick();
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_checks++;
            if (accumulate_export !== (i >= 7) || accumulate_pulse !== (i == 7)) begin
                n_fail++;
                $display("FAIL mid_reset_release edge=%0d got lvl=%b pls=%b expected lvl=%b pls=%b",
                         i, accumulate_export, accumulate_pulse, i >= 7, i == 7);
            end
        end
        settle();
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 60; seg++) begin
            hold = $urandom_range(1, 9);
            key_clear_n = 1'($urandom_range(0, 1));
            key_accum_n = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: sw_raw = 8'h00;
                1: sw_raw = 8'h3C;
                2: sw_raw = 8'hFF;
                default: sw_raw = 8'($urandom);
            endcase
            for (int c = 0; c < hold; c++) begin
                tick();
                n_checks++;
                if (clear_export !== mc.lvl || clear_pulse !== mc.pls ||
                    accumulate_export !== ma.lvl || accumulate_pulse !== m_acc_pulse ||
                    switch_export !== ms_exp) begin
                    n_fail++;
                    $display("FAIL random seg=%0d got clr=%b/%b acc=%b/%b sw=%h expected clr=%b/%b acc=%b/%b sw=%h",
                             seg, clear_export, clear_pulse, accumulate_export, accumulate_pulse, switch_export,
                             mc.lvl, mc.pls, ma.lvl, m_acc_pulse, ms_exp);
                end
            end
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_switch_glitch();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
